// File: rtl/ppc_types.sv
// Shared types for the out-of-order core: reservation-station slot state,
// operand records and the common-result-bus snoop helper.
package ppc_types;

    localparam int RS_TAG_W  = 5;
    localparam int RS_DATA_W = 32;
    localparam int RS_OP_W   = 32;

    typedef enum logic [1:0] {
        RS_FREE    = 2'd0,
        RS_WAITING = 2'd1,
        RS_READY   = 2'd2,
        RS_ISSUED  = 2'd3
    } rs_state_t;

    typedef struct packed {
        logic                 valid;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] value;
    } rs_operand_t;

    typedef struct packed {
        rs_state_t            state;
        logic [RS_OP_W-1:0]   op;
        rs_operand_t          a;
        rs_operand_t          b;
    } rs_entry_t;

    // An unresolved operand whose producer tag is on the bus takes the value.
    function automatic rs_operand_t rs_snoop(input rs_operand_t opnd,
                                             input logic cdb_valid,
                                             input logic [RS_TAG_W-1:0] cdb_tag,
                                             input logic [RS_DATA_W-1:0] cdb_value);
        rs_operand_t res;
        res = opnd;
        if (!opnd.valid && cdb_valid && (opnd.tag == cdb_tag)) begin
            res.valid = 1'b1;
            res.value = cdb_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_slot.sv
// One reservation-station slot: FREE/WAITING/READY/ISSUED state machine,
// operand snooping and release when its own tag comes back on the bus.
module rs_slot
    import ppc_types::*;
#(
    parameter logic [RS_TAG_W-1:0] SLOT_TAG = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alloc,
    input  logic                 issue,
    input  logic [RS_OP_W-1:0]   op_in,
    input  rs_operand_t          src_a,
    input  rs_operand_t          src_b,
    input  logic                 cdb_valid,
    input  logic [RS_TAG_W-1:0]  cdb_tag,
    input  logic [RS_DATA_W-1:0] cdb_value,
    output rs_state_t            state,
    output logic [RS_OP_W-1:0]   op,
    output logic [RS_DATA_W-1:0] a_value,
    output logic [RS_DATA_W-1:0] b_value
);

    rs_entry_t entry_q;
    rs_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        unique case (entry_q.state)
            RS_FREE: begin
                if (alloc) begin
                    entry_d.op    = op_in;
                    entry_d.a     = rs_snoop(src_a, cdb_valid, cdb_tag, cdb_value);
                    entry_d.b     = rs_snoop(src_b, cdb_valid, cdb_tag, cdb_value);
                    entry_d.state = (entry_d.a.valid && entry_d.b.valid) ? RS_READY : RS_WAITING;
                end
            end
            RS_WAITING: begin
                entry_d.a = rs_snoop(entry_q.a, cdb_valid, cdb_tag, cdb_value);
                entry_d.b = rs_snoop(entry_q.b, cdb_valid, cdb_tag, cdb_value);
                if (entry_d.a.valid && entry_d.b.valid) begin
                    entry_d.state = RS_READY;
                end
            end
            RS_READY: begin
                if (issue) begin
                    entry_d.state = RS_ISSUED;
                end
            end
            RS_ISSUED: begin
                // Hold the tag until the result is broadcast so it cannot alias.
                if (cdb_valid && (cdb_tag == SLOT_TAG)) begin
                    entry_d.state = RS_FREE;
                end
            end
            default: entry_d.state = RS_FREE;
        endcase
        if (flush) begin
            entry_d.state = RS_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign state   = entry_q.state;
    assign op      = entry_q.op;
    assign a_value = entry_q.a.value;
    assign b_value = entry_q.b.value;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops in tagged slots until operands
// arrive on the result bus, then issues them through a registered stage.
module reservation_station
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = RS_TAG_W,
    parameter int RS_OFFSET   = 0,
    parameter int ENTRIES     = 4,
    parameter int OP_WIDTH    = RS_OP_W,
    parameter int DATA_WIDTH  = RS_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [OP_WIDTH-1:0]    op_in,
    output logic [RS_ID_WIDTH-1:0] alloc_tag,
    input  logic                   src_a_valid,
    input  logic [RS_ID_WIDTH-1:0] src_a_tag,
    input  logic [DATA_WIDTH-1:0]  src_a_value,
    input  logic                   src_b_valid,
    input  logic [RS_ID_WIDTH-1:0] src_b_tag,
    input  logic [DATA_WIDTH-1:0]  src_b_value,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_tag,
    input  logic [DATA_WIDTH-1:0]  cdb_value,
    input  logic                   flush,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [OP_WIDTH-1:0]    issue_op,
    output logic [DATA_WIDTH-1:0]  issue_a,
    output logic [DATA_WIDTH-1:0]  issue_b,
    output logic [RS_ID_WIDTH-1:0] issue_tag
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Both ports use valid/ready: a transfer happens on a clock edge where
    // valid and ready are both high; the sender holds its payload until then.

    rs_state_t              slot_state [ENTRIES];
    logic [OP_WIDTH-1:0]    slot_op    [ENTRIES];
    logic [DATA_WIDTH-1:0]  slot_a     [ENTRIES];
    logic [DATA_WIDTH-1:0]  slot_b     [ENTRIES];

    logic [ENTRIES-1:0]     free_vec;
    logic [ENTRIES-1:0]     ready_vec;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       ready_idx;
    logic                   any_free;
    logic                   any_ready;
    logic                   dispatch;
    logic                   load_out;
    rs_operand_t            src_a_opnd;
    rs_operand_t            src_b_opnd;

    assign src_a_opnd = '{valid: src_a_valid, tag: src_a_tag, value: src_a_value};
    assign src_b_opnd = '{valid: src_b_valid, tag: src_b_tag, value: src_b_value};

    always_comb begin
        free_idx  = '0;
        ready_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i])  free_idx  = IDX_W'(i);
            if (ready_vec[i]) ready_idx = IDX_W'(i);
        end
    end

    assign any_free    = |free_vec;
    assign any_ready   = |ready_vec;
    assign input_ready = any_free && !rst;
    assign alloc_tag   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx);
    assign dispatch    = input_valid && input_ready;
    assign load_out    = !issue_valid || issue_ready;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
        assign free_vec[i]  = (slot_state[i] == RS_FREE);
        assign ready_vec[i] = (slot_state[i] == RS_READY);

        rs_slot #(
            .SLOT_TAG (RS_TAG_W'(RS_OFFSET + i))
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .alloc     (dispatch && (free_idx == IDX_W'(i))),
            .issue     (load_out && any_ready && (ready_idx == IDX_W'(i))),
            .op_in     (op_in),
            .src_a     (src_a_opnd),
            .src_b     (src_b_opnd),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .state     (slot_state[i]),
            .op        (slot_op[i]),
            .a_value   (slot_a[i]),
            .b_value   (slot_b[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issue_valid <= 1'b0;
            issue_op    <= '0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_tag   <= '0;
        end else if (load_out) begin
            issue_valid <= any_ready;
            if (any_ready) begin
                issue_op  <= slot_op[ready_idx];
                issue_a   <= slot_a[ready_idx];
                issue_b   <= slot_b[ready_idx];
                issue_tag <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(ready_idx);
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with RS_OFFSET=8, ENTRIES=4:
// expected issues are queued at dispatch and checked by a negedge monitor.
module tb_reservation_station;

    localparam int TW = 5;
    localparam int DW = 32;
    localparam int OW = 32;
    localparam int EW = OW + 2 * DW + TW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [OW-1:0] op_in = '0;
    logic [TW-1:0] alloc_tag;
    logic          src_a_valid = 1'b0;
    logic [TW-1:0] src_a_tag = '0;
    logic [DW-1:0] src_a_value = '0;
    logic          src_b_valid = 1'b0;
    logic [TW-1:0] src_b_tag = '0;
    logic [DW-1:0] src_b_value = '0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_value = '0;
    logic          flush = 1'b0;
    logic          issue_valid;
    logic          issue_ready = 1'b1;
    logic [OW-1:0] issue_op;
    logic [DW-1:0] issue_a;
    logic [DW-1:0] issue_b;
    logic [TW-1:0] issue_tag;

    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    reservation_station #(
        .RS_ID_WIDTH (TW),
        .RS_OFFSET   (8),
        .ENTRIES     (4),
        .OP_WIDTH    (OW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .op_in       (op_in),
        .alloc_tag   (alloc_tag),
        .src_a_valid (src_a_valid),
        .src_a_tag   (src_a_tag),
        .src_a_value (src_a_value),
        .src_b_valid (src_b_valid),
        .src_b_tag   (src_b_tag),
        .src_b_value (src_b_value),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_tag   (issue_tag)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [TW-1:0] tag);
        return {op, a, b, tag};
    endfunction

    // Monitor: every accepted issue must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got tag %0d op 0x%0h, expected no issue", issue_tag, issue_op);
            end else begin
                check("issue_payload", {issue_op, issue_a, issue_b, issue_tag}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [OW-1:0] op,
                            input logic av, input logic [TW-1:0] at, input logic [DW-1:0] aval,
                            input logic bv, input logic [TW-1:0] bt, input logic [DW-1:0] bval);
        input_valid = 1'b1;
        op_in       = op;
        src_a_valid = av;
        src_a_tag   = at;
        src_a_value = aval;
        src_b_valid = bv;
        src_b_tag   = bt;
        src_b_value = bval;
        cycle();
        input_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [TW-1:0] tag, input logic [DW-1:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = val;
        cycle();
        cdb_valid = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) cycle();
        check("rst_input_ready", input_ready, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_outputs", {issue_op, issue_a, issue_b, issue_tag}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_input_ready", input_ready, 1);
        check("post_rst_alloc_tag", alloc_tag, 8);

        // 1: fully resolved op, then release of slot 0 by its tag
        exp_q.push_back(pack_exp(32'h1234, 32'd5, 32'd7, 5'd8));
        dispatch(32'h1234, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        check("t1_no_issue_at_t", issue_valid, 0);
        check("t1_alloc_next", alloc_tag, 9);
        cycle();
        check("t1_issue_valid", issue_valid, 1);
        cycle();
        check("t1_issue_drained", issue_valid, 0);
        check("t1_slot_held", alloc_tag, 9);
        broadcast(5'd8, 32'd0);
        check("t1_slot_freed", alloc_tag, 8);

        // 2: operand A waits on tag 3
        exp_q.push_back(pack_exp(32'h2222, 32'hDEAD, 32'd1, 5'd8));
        dispatch(32'h2222, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd1);
        cycle();
        cycle();
        check("t2_waiting", issue_valid, 0);
        broadcast(5'd3, 32'hDEAD);
        check("t2_capture_edge", issue_valid, 0);
        cycle();
        check("t2_issue_valid", issue_valid, 1);
        check("t2_issue_a", issue_a, 32'hDEAD);
        cycle();
        broadcast(5'd8, 32'd0);

        // 3: same-cycle bypass from the result bus
        exp_q.push_back(pack_exp(32'h3333, 32'h77, 32'd2, 5'd8));
        cdb_valid = 1'b1;
        cdb_tag   = 5'd3;
        cdb_value = 32'h77;
        dispatch(32'h3333, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd2);
        cdb_valid = 1'b0;
        check("t3_no_issue_at_t", issue_valid, 0);
        cycle();
        check("t3_issue_valid", issue_valid, 1);
        check("t3_issue_a", issue_a, 32'h77);
        cycle();
        broadcast(5'd8, 32'd0);

        // 4: fill all slots, then release tag 9
        for (int i = 0; i < 4; i++) begin
            check("t4_alloc_tag", alloc_tag, 5'(8 + i));
            check("t4_input_ready", input_ready, 1);
            exp_q.push_back(pack_exp(32'(32'h4000 + i), 32'(i * 3), 32'(100 + i), 5'(8 + i)));
            dispatch(32'(32'h4000 + i), 1'b1, 5'd0, 32'(i * 3), 1'b1, 5'd0, 32'(100 + i));
        end
        check("t4_full", input_ready, 0);
        repeat (3) cycle();
        check("t4_all_issued", issue_valid, 0);
        check("t4_still_full", input_ready, 0);
        broadcast(5'd9, 32'd0);
        check("t4_freed_ready", input_ready, 1);
        check("t4_freed_tag", alloc_tag, 9);
        broadcast(5'd8, 32'd0);
        broadcast(5'd10, 32'd0);
        broadcast(5'd11, 32'd0);
        check("t4_all_free", alloc_tag, 8);

        // 5: stall holds outputs, then back-to-back issue
        issue_ready = 1'b0;
        exp_q.push_back(pack_exp(32'h5000, 32'd1, 32'd2, 5'd8));
        exp_q.push_back(pack_exp(32'h5001, 32'd3, 32'd4, 5'd9));
        dispatch(32'h5000, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
        dispatch(32'h5001, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4);
        for (int k = 0; k < 5; k++) begin
            check("t5_stall_valid", issue_valid, 1);
            check("t5_stall_hold", {issue_op, issue_a, issue_b, issue_tag},
                  pack_exp(32'h5000, 32'd1, 32'd2, 5'd8));
            cycle();
        end
        issue_ready = 1'b1;
        cycle();
        check("t5_next_valid", issue_valid, 1);
        check("t5_next_tag", issue_tag, 9);
        cycle();
        check("t5_drained", issue_valid, 0);
        broadcast(5'd8, 32'd0);
        broadcast(5'd9, 32'd0);

        // 6: flush beats a simultaneous dispatch
        issue_ready = 1'b0;
        dispatch(32'h6000, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
        dispatch(32'h6001, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd2);
        dispatch(32'h6002, 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'd3);
        check("t6_pre_flush_valid", issue_valid, 1);
        check("t6_pre_flush_tag", alloc_tag, 11);
        flush = 1'b1;
        dispatch(32'h6666, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
        flush = 1'b0;
        check("t6_flush_valid", issue_valid, 0);
        check("t6_flush_ready", input_ready, 1);
        check("t6_flush_tag", alloc_tag, 8);
        issue_ready = 1'b1;
        repeat (3) cycle();
        check("t6_nothing_issued", issue_valid, 0);
        check("t6_still_empty", alloc_tag, 8);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
